// File: rtl/adder_pkg.sv
// adder_pkg: shared definitions for the pipelined adder/subtractor.
//   OP_*     : operation encodings carried on the op port.
//   chunk_w  : bits per pipeline stage (operand width / stage count).
package adder_pkg;

  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_SUB     = 2'b01;
  localparam logic [1:0] OP_ADD_SAT = 2'b10;
  localparam logic [1:0] OP_SUB_SAT = 2'b11;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_chunk_stage.sv
// adder_chunk_stage: one registered C-bit slice of the carry-ripple pipeline.
//   clk, rst_n : clock, async active-low reset
//   en         : global pipeline advance
//   vld_in     : valid bit entering this slice
//   a, b, cin  : chunk operands and carry from the previous slice
//   vld        : registered valid
//   s, cout    : registered chunk sum and carry out
module adder_chunk_stage #(
  parameter int C = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         vld_in,
  input  logic [C-1:0] a,
  input  logic [C-1:0] b,
  input  logic         cin,
  output logic         vld,
  output logic [C-1:0] s,
  output logic         cout
);

  logic [C:0] sum_d;

  assign sum_d = {1'b0, a} + {1'b0, b} + {{C{1'b0}}, cin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      s    <= '0;
      cout <= 1'b0;
    end else if (en) begin
      vld  <= vld_in;
      s    <= sum_d[C-1:0];
      cout <= sum_d[C];
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/sub, carry ripples one C-bit chunk per stage.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : operand handshake (in_ready = global enable)
//   a, b, op            : operands and operation (ADD, SUB, ADD_SAT, SUB_SAT)
//   out_valid/out_ready : result handshake
//   sum                 : WIDTH+1 result; top bit is carry, borrow or sat flag
// WIDTH must be a multiple of STAGES.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
);

  localparam int C = chunk_w(WIDTH, STAGES);

  logic                         en;
  logic [WIDTH-1:0]             bx;
  logic [STAGES-1:0][C-1:0]     ca, cb, s_q, rq;
  logic [STAGES-1:0]            co_q, vld_q;
  logic [STAGES-1:0][1:0]       op_q;
  logic [WIDTH-1:0]             raw;
  logic                         cout;
  logic [1:0]                   op_l;

  // Whole pipe stalls as one unit whenever the output is held.
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_q[STAGES-1];

  // op[0] marks both subtract flavours: invert b and inject carry 1.
  assign bx    = op[0] ? ~b : b;
  assign ca[0] = a[C-1:0];
  assign cb[0] = bx[C-1:0];

  // Skew: chunk j of a and b' waits j cycles to meet its carry.
  for (genvar j = 1; j < STAGES; j++) begin : g_skew
    logic [j-1:0][C-1:0] ad, bd;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ad <= '0;
        bd <= '0;
      end else if (en) begin
        ad[0] <= a[j*C +: C];
        bd[0] <= bx[j*C +: C];
        for (int i = 1; i < j; i++) begin
          ad[i] <= ad[i-1];
          bd[i] <= bd[i-1];
        end
      end
    end
    assign ca[j] = ad[j-1];
    assign cb[j] = bd[j-1];
  end

  // Op travels with the entry so the final stage knows how to format it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
    end else if (en) begin
      op_q[0] <= op;
      for (int k = 1; k < STAGES; k++) op_q[k] <= op_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic vin, cin;
    if (k == 0) begin : g_first
      assign vin = in_valid;
      assign cin = op[0];
    end else begin : g_next
      assign vin = vld_q[k-1];
      assign cin = co_q[k-1];
    end

    adder_chunk_stage #(.C(C)) u_chunk (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .vld_in (vin),
      .a      (ca[k]),
      .b      (cb[k]),
      .cin    (cin),
      .vld    (vld_q[k]),
      .s      (s_q[k]),
      .cout   (co_q[k])
    );
  end

  // De-skew: chunk j result waits STAGES-1-j cycles to line up with the top.
  for (genvar j = 0; j < STAGES - 1; j++) begin : g_deskew
    localparam int D = STAGES - 1 - j;
    logic [D-1:0][C-1:0] rd;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd <= '0;
      end else if (en) begin
        rd[0] <= s_q[j];
        for (int i = 1; i < D; i++) rd[i] <= rd[i-1];
      end
    end
    assign rq[j] = rd[D-1];
  end
  assign rq[STAGES-1] = s_q[STAGES-1];

  assign raw  = rq;
  assign cout = co_q[STAGES-1];
  assign op_l = op_q[STAGES-1];

  // Formatting is a pure function of the last stage's registers, so sum
  // holds while stalled and is zero out of reset (op = ADD, data = 0).
  always_comb begin
    sum = {cout, raw};
    case (op_l)
      OP_ADD:     sum = {cout, raw};
      OP_SUB:     sum = {~cout, raw};
      OP_ADD_SAT: sum = cout  ? {1'b1, {WIDTH{1'b1}}} : {1'b0, raw};
      OP_SUB_SAT: sum = !cout ? {1'b1, {WIDTH{1'b0}}} : {1'b0, raw};
      default:    sum = {cout, raw};
    endcase
  end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined WIDTH-bit adder/subtractor with valid/ready handshakes on both sides and selectable wrapping or saturating arithmetic. Operands are split into STAGES equal chunks, and the carry ripples through one chunk per clock, so throughput is one operation per cycle at any width. It is the next generation of the team's 8-bit combinational adder: it sits between a streaming operand source and a result consumer that may apply backpressure.

## Interface
Parameters:
- WIDTH, 16: operand width in bits; must be divisible by STAGES.
- STAGES, 4: number of pipeline register stages; chunk width C = WIDTH/STAGES; 1 ≤ STAGES ≤ WIDTH.

Ports:
- clk  in  1: single clock, rising edge.
- rst_n  in  1: reset, asynchronous and active-low.
- in_valid  in  1: operands a, b and op are valid.
- in_ready  out  1: block accepts operands this cycle.
- a  in  WIDTH: unsigned operand A.
- b  in  WIDTH: unsigned operand B.
- op  in  2: operation; 00 ADD, 01 SUB (a−b), 10 ADD_SAT, 11 SUB_SAT.
- out_valid  out  1: result is valid.
- out_ready  in  1: consumer accepts the result.
- sum  out  WIDTH+1: result; see Operation for the meaning of bit WIDTH.

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready at a rising edge.
- Global enable: en = !out_valid || out_ready. in_ready = en. All stages advance only when en = 1. The whole pipe stalls as one unit; there are no bubbles to collapse.
- Bubbles: when in_valid = 0 with en = 1, an invalid entry enters stage 1. Every stage carries its own valid bit.
- Stage k (k = 0..STAGES−1) adds chunk k of a and b′ plus the carry from stage k−1. Upper chunks and op travel unchanged alongside the data as skew registers. Lower result chunks are carried forward as de-skew registers.
- SUB and SUB_SAT: b′ = ~b and the initial carry is 1. ADD and ADD_SAT: b′ = b and the initial carry is 0.
- The final stage computes raw = WIDTH-bit sum and cout = carry out of the top chunk, then registers sum as follows:
  - ADD: {cout, raw}. This is the full (WIDTH+1)-bit sum.
  - SUB: {~cout, raw}. Bit WIDTH is the borrow; raw is a−b mod 2^WIDTH.
  - ADD_SAT: if cout is set, {1, all-ones}; otherwise {0, raw}. Bit WIDTH is the saturation flag.
  - SUB_SAT: if ~cout is set, {1, zero}; otherwise {0, raw}. Bit WIDTH is the saturation flag.
- Entries leave in the order they were accepted. No operation is lost or duplicated under any out_ready pattern.

## Timing
- Reset (rst_n low, asynchronous): all stage valids, out_valid and sum are cleared to 0. in_ready is 1 during and after reset, since out_valid = 0.
- Reset mid-operation discards every in-flight entry. The first result after reset belongs to the first operation accepted after reset.
- Latency: an operation accepted on edge n with no stalls drives out_valid = 1 after edge n+STAGES−1. With STAGES = 1, out_valid rises directly after the capture edge.
- Throughput: one operation per cycle while out_ready = 1.
- Stall behaviour when out_valid = 1 and out_ready = 0:
  - in_ready drops combinationally in the same cycle.
  - sum and out_valid hold stable until the output transfer.
  - All internal stages hold their contents.
- Simultaneous input and output transfer on the same edge is legal and is the steady state.
- in_ready depends combinationally on out_ready. There are no other combinational input-to-output paths.

## Structure
- Package adder_pkg holds the op encodings as localparams (OP_ADD = 2'b00, OP_SUB = 2'b01, OP_ADD_SAT = 2'b10, OP_SUB_SAT = 2'b11) and a chunk-width helper function.
- Sub-module adder_chunk_stage is a single registered C-bit add slice with carry in/out, enable and valid. The top level instantiates STAGES of these with a generate loop, plus the skew/de-skew registers and the output saturation logic.

## Test plan
All scenarios use WIDTH = 8 and STAGES = 4 (C = 2) unless stated.
1. ADD a=255, b=255, out_ready=1 → sum=9'h1FE, out_valid exactly 3 edges after the capture edge.
2. SUB a=3, b=99 → sum=9'h1A0 (borrow=1, low byte 160). SUB a=99, b=3 → sum=9'h060.
3. ADD_SAT a=101, b=166 → sum=9'h1FF. ADD_SAT a=101, b=66 → sum=9'h0A7. SUB_SAT a=3, b=99 → sum=9'h100.
4. Stream 6 back-to-back ops and hold out_ready=0 for 3 cycles mid-stream → in_ready low while stalled, sum held stable, all 6 results delivered in order with no loss or duplication.
5. Assert rst_n low with 3 entries in flight → out_valid=0 and sum=0 immediately. After release, only post-reset operations appear at the output.
6. Repeat scenarios 1–3 with STAGES=1 and STAGES=8 → identical results; latency of 1 and 8 cycles respectively.
